operand_stage: RTL and testbench
================================

# operand_stage

Upstream neighbour of the ALU: holds the integer register file and a one-entry ID/EX pipeline register. It accepts a decoded instruction's register addresses, immediate and 3-bit ALU operation. It reads the operands, selects register or immediate for the second operand, and presents `input_a`, `input_b` and `operation` to the ALU behind a valid/ready handshake. Write-back from the end of the pipeline also enters here.

## Interface
- `WORDSIZE`, 64, datapath width; matches the ALU.
- `REGCOUNT`, 32, number of architectural registers.
- `REGADDR`, 5, register address width; must equal clog2(`REGCOUNT`).

- `clk` in 1: the single clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `in_valid` in 1: decoded instruction present.
- `in_ready` out 1: stage can accept this cycle.
- `rs1_addr` in `REGADDR`: source register for `input_a`.
- `rs2_addr` in `REGADDR`: source register for `input_b` when `use_imm`=0.
- `imm` in `WORDSIZE`: sign-extended immediate.
- `use_imm` in 1: 1 selects `imm` as `input_b`.
- `op_in` in 3: ALU operation code.
- `wb_en` in 1: write-back strobe.
- `wb_addr` in `REGADDR`: write-back destination.
- `wb_data` in `WORDSIZE`: write-back value.
- `out_valid` out 1: ALU operands valid.
- `out_ready` in 1: ALU side consumes this cycle.
- `input_a` out `WORDSIZE`: first ALU operand.
- `input_b` out `WORDSIZE`: second ALU operand.
- `operation` out 3: ALU operation.

## Operation
- Register file:
  - `REGCOUNT` x `WORDSIZE` bits.
  - Two combinational read ports, one synchronous write port.
  - Register 0 always reads 0; writes to address 0 are discarded.
  - All registers clear to 0 on `rst`.
- Write: on a rising edge with `wb_en`=1 and `wb_addr`≠0, `wb_data` is stored.
- Accept: occurs when `in_valid && in_ready`, with `in_ready = !out_valid || out_ready`. On accept, the pipeline register captures:
  - `input_a` = R[`rs1_addr`]
  - `input_b` = `use_imm` ? `imm` : R[`rs2_addr`]
  - `operation` = `op_in`
  - the source addresses and `use_imm`, kept for bypass.
- `out_valid` next-state:
  - set on accept;
  - else cleared when `out_ready`=1;
  - else held.
- Stall (`out_valid`=1, `out_ready`=0): outputs hold stable. `in_ready`=0.
- Simultaneous consume and accept: the new entry replaces the old in the same edge. There is no bubble, and `out_valid` stays 1.
- No arithmetic is done here; widths pass through unchanged.
- Reset mid-operation: any held entry is dropped and registers are cleared.

## Timing
- Reset values:
  - `out_valid`=0, `input_a`=0, `input_b`=0, `operation`=0.
  - `in_ready`=1 (derived from `out_valid`).
- Latency: accept at edge N gives `out_valid`=1 and operands visible after edge N. This is one cycle.
- Throughput: one instruction per cycle while `out_ready`=1.
- Write-back visibility without bypass: a write at edge N is visible to reads accepted at edge N+1 or later.
- Write and read of the same register in the same edge: resolved by the configuration below.

## Configuration
- Macro: `OPERAND_BYPASS_EN`.
- Defined:
  - On accept, any operand whose source address equals `wb_addr` (with `wb_en`=1 and address ≠0) captures `wb_data` instead of the stale register value.
  - While stalled, a held register-sourced operand whose stored address matches an active write-back is updated with `wb_data`. `imm` operands are never touched.
- Undefined:
  - The captured operand is the pre-write register value.
  - Held operands never change while stalled.
  - Upstream hazard logic must insert stalls.

## Structure
- Shared package `riscv_pkg`:
  - `WORDSIZE` and `REGADDR` defaults;
  - 3-bit ALU operation encodings, shared with the ALU;
  - `REG_ZERO` constant (0).
- Sub-module `regfile`: storage, the two read ports, the write port and zero-register rule.
- The top holds the handshake, operand mux, pipeline register and bypass.

## Test plan
- Reset check: assert `rst` mid-stall with `out_valid`=1 -> `out_valid`=0, outputs 0, `in_ready`=1, and all registers read 0 afterwards.
- Basic issue: write x5=0x1234 at edge 1. At edge 3, accept rs1=5, rs2=0, `use_imm`=0, op=3 -> after edge 3, `input_a`=0x1234, `input_b`=0, `operation`=3, `out_valid`=1.
- Zero register: write x0=0xFF, then read rs1=0 -> `input_a`=0.
- Immediate select: `use_imm`=1, `imm`=0xFFFF_FFFF_FFFF_FFF0 -> `input_b`=0xFFFF_FFFF_FFFF_FFF0 regardless of `rs2_addr`.
- Stall: `out_ready`=0 for 3 cycles with `in_valid`=1 -> `in_ready`=0 and outputs constant. Raise `out_ready` -> the next instruction is accepted on that same edge and `out_valid` stays 1.
- Same-edge write/read: x7=0x10, then accept rs1=7 with `wb_en`=1, `wb_addr`=7, `wb_data`=0x20 -> `input_a`=0x20 with `OPERAND_BYPASS_EN`, and 0x10 without it.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the integer pipeline: datapath widths, ALU operation
// encodings and the hard-wired zero register address.
package riscv_pkg;

  localparam int WORDSIZE = 64;
  localparam int REGCOUNT = 32;
  localparam int REGADDR  = 5;
  localparam int OP_W     = 3;

  localparam logic [REGADDR-1:0] REG_ZERO = '0;

  // Encodings must stay in step with the ALU decoder.
  typedef enum logic [OP_W-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SRA = 3'd7
  } alu_op_e;

endpackage

// File: rtl/operand_stage_regfile.sv
// Integer register file: two combinational read ports, one synchronous write
// port; register 0 is hard-wired to zero.
module regfile
  import riscv_pkg::*;
#(
  parameter int WORDSIZE = riscv_pkg::WORDSIZE,
  parameter int REGCOUNT = riscv_pkg::REGCOUNT,
  parameter int REGADDR  = riscv_pkg::REGADDR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REGADDR-1:0]  rd1_addr,
  output logic [WORDSIZE-1:0] rd1_data,
  input  logic [REGADDR-1:0]  rd2_addr,
  output logic [WORDSIZE-1:0] rd2_data,
  input  logic                we,
  input  logic [REGADDR-1:0]  wr_addr,
  input  logic [WORDSIZE-1:0] wr_data
);

  localparam logic [REGADDR-1:0] ZERO_ADDR = REGADDR'(REG_ZERO);

  logic [WORDSIZE-1:0] r_mem [REGCOUNT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REGCOUNT; i++) r_mem[i] <= '0;
    end else if (we && (wr_addr != ZERO_ADDR)) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd1_data = (rd1_addr == ZERO_ADDR) ? '0 : r_mem[rd1_addr];
  assign rd2_data = (rd2_addr == ZERO_ADDR) ? '0 : r_mem[rd2_addr];

endmodule

// File: rtl/operand_stage.sv
// ID/EX operand stage: register read, immediate select and a one-entry output
// register behind valid/ready. Define OPERAND_BYPASS_EN to forward write-back data.
module operand_stage
  import riscv_pkg::*;
#(
  parameter int WORDSIZE = riscv_pkg::WORDSIZE,
  parameter int REGCOUNT = riscv_pkg::REGCOUNT,
  parameter int REGADDR  = riscv_pkg::REGADDR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [REGADDR-1:0]  rs1_addr,
  input  logic [REGADDR-1:0]  rs2_addr,
  input  logic [WORDSIZE-1:0] imm,
  input  logic                use_imm,
  input  logic [OP_W-1:0]     op_in,
  input  logic                wb_en,
  input  logic [REGADDR-1:0]  wb_addr,
  input  logic [WORDSIZE-1:0] wb_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORDSIZE-1:0] input_a,
  output logic [WORDSIZE-1:0] input_b,
  output logic [OP_W-1:0]     operation
);

  logic                r_valid;
  logic [WORDSIZE-1:0] r_a;
  logic [WORDSIZE-1:0] r_b;
  logic [OP_W-1:0]     r_op;

  logic [WORDSIZE-1:0] w_rd1;
  logic [WORDSIZE-1:0] w_rd2;
  logic [WORDSIZE-1:0] w_a_sel;
  logic [WORDSIZE-1:0] w_b_sel;
  logic                w_accept;

  regfile #(
    .WORDSIZE(WORDSIZE),
    .REGCOUNT(REGCOUNT),
    .REGADDR (REGADDR)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .rd1_addr(rs1_addr),
    .rd1_data(w_rd1),
    .rd2_addr(rs2_addr),
    .rd2_data(w_rd2),
    .we      (wb_en),
    .wr_addr (wb_addr),
    .wr_data (wb_data)
  );

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;

`ifdef OPERAND_BYPASS_EN
  logic               w_wb_hit;
  logic [REGADDR-1:0] r_rs1;
  logic [REGADDR-1:0] r_rs2;
  logic               r_use_imm;

  assign w_wb_hit = wb_en && (wb_addr != REGADDR'(REG_ZERO));
  assign w_a_sel  = (w_wb_hit && (wb_addr == rs1_addr)) ? wb_data : w_rd1;
  assign w_b_sel  = use_imm ? imm :
                    ((w_wb_hit && (wb_addr == rs2_addr)) ? wb_data : w_rd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_use_imm <= 1'b0;
    end else if (w_accept) begin
      r_rs1     <= rs1_addr;
      r_rs2     <= rs2_addr;
      r_use_imm <= use_imm;
    end
  end
`else
  assign w_a_sel = w_rd1;
  assign w_b_sel = use_imm ? imm : w_rd2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_a     <= w_a_sel;
      r_b     <= w_b_sel;
      r_op    <= op_in;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
`ifdef OPERAND_BYPASS_EN
    // A stalled entry must not carry a value that write-back just superseded.
    else if (r_valid) begin
      if (w_wb_hit && (r_rs1 == wb_addr)) r_a <= wb_data;
      if (w_wb_hit && !r_use_imm && (r_rs2 == wb_addr)) r_b <= wb_data;
    end
`endif
  end

  assign out_valid = r_valid;
  assign input_a   = r_a;
  assign input_b   = r_b;
  assign operation = r_op;

endmodule

// File: tb/tb_operand_stage.sv
// Self-checking bench for operand_stage: a register model predicts each accepted
// instruction's operands into a queue, which is compared as the ALU side consumes.
module tb_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [63:0] imm;
  logic        use_imm;
  logic [2:0]  op_in;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic        out_valid, out_ready;
  logic [63:0] input_a, input_b;
  logic [2:0]  operation;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        ui;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] model[32];
  int          n_checks = 0;
  int          n_fail   = 0;

  operand_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .imm(imm), .use_imm(use_imm), .op_in(op_in),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .input_a(input_a), .input_b(input_b), .operation(operation)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; rs1_addr = 0; rs2_addr = 0; imm = 0; use_imm = 0; op_in = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic ui,
                       input logic [63:0] im, input logic [2:0] op);
    in_valid = 1; rs1_addr = r1; rs2_addr = r2; use_imm = ui; imm = im; op_in = op;
  endtask

  task automatic write_back(input logic en, input logic [4:0] addr, input logic [63:0] data);
    wb_en = en; wb_addr = addr; wb_data = data;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = '0;
    sb.delete();
  endtask

  // Monitor: inputs settle 1 time unit after each rising edge; the falling edge
  // sees exactly what the next rising edge will act on.
  always @(negedge clk) begin
    if (!rst) begin
      logic hit;
      hit = wb_en && (wb_addr != 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("input_a", input_a, e.a);
          chk("input_b", input_b, e.b);
          chk("operation", {61'd0, operation}, {61'd0, e.op});
        end
      end
`ifdef OPERAND_BYPASS_EN
      else if (out_valid && hit && sb.size() > 0) begin
        if (sb[0].rs1 == wb_addr) sb[0].a = wb_data;
        if (!sb[0].ui && sb[0].rs2 == wb_addr) sb[0].b = wb_data;
      end
`endif
      if (in_valid && in_ready) begin
        exp_t e;
        e.rs1 = rs1_addr; e.rs2 = rs2_addr; e.ui = use_imm; e.op = op_in;
        e.a = model[rs1_addr];
        e.b = use_imm ? imm : model[rs2_addr];
`ifdef OPERAND_BYPASS_EN
        if (hit && wb_addr == rs1_addr) e.a = wb_data;
        if (hit && !use_imm && wb_addr == rs2_addr) e.b = wb_data;
`endif
        sb.push_back(e);
      end
      if (hit) model[wb_addr] = wb_data;
    end
  end

  initial begin
    logic [63:0] hold_a, hold_b;
    logic [2:0]  hold_op;
    int          budget;

    idle_inputs();
    out_ready = 1;
    rst = 1;
    clear_model();
    step(); step();
    chk("rst_out_valid", {63'd0, out_valid}, 0);
    chk("rst_in_ready", {63'd0, in_ready}, 1);
    chk("rst_input_a", input_a, 0);
    chk("rst_input_b", input_b, 0);
    chk("rst_operation", {61'd0, operation}, 0);
    rst = 0;
    step();

    // Basic issue: x5 written, read two edges later.
    write_back(1, 5'd5, 64'h1234);
    step();
    idle_inputs();
    step();
    issue(5'd5, 5'd0, 0, 64'h0, 3'd3);
    step();
    idle_inputs();
    chk("lat_out_valid", {63'd0, out_valid}, 1);
    chk("basic_a", input_a, 64'h1234);
    chk("basic_b", input_b, 64'h0);
    chk("basic_op", {61'd0, operation}, 3);
    step();

    // Zero register ignores writes.
    write_back(1, 5'd0, 64'hFF);
    step();
    idle_inputs();
    issue(5'd0, 5'd0, 0, 64'h0, 3'd1);
    step();
    idle_inputs();
    chk("zero_a", input_a, 64'h0);

    // Immediate overrides rs2.
    issue(5'd0, 5'd5, 1, 64'hFFFF_FFFF_FFFF_FFF0, 3'd0);
    step();
    idle_inputs();
    chk("imm_b", input_b, 64'hFFFF_FFFF_FFFF_FFF0);

    // Stall: held entry stays put for three cycles, then consume+accept together.
    write_back(1, 5'd9, 64'hABCD);
    step();
    idle_inputs();
    issue(5'd9, 5'd5, 0, 64'h0, 3'd4);
    step();
    out_ready = 0;
    issue(5'd5, 5'd9, 0, 64'h0, 3'd6);
    hold_a = input_a; hold_b = input_b; hold_op = operation;
    chk("stall_first_a", hold_a, 64'hABCD);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_in_ready", {63'd0, in_ready}, 0);
      chk("stall_out_valid", {63'd0, out_valid}, 1);
      chk("stall_hold_a", input_a, hold_a);
      chk("stall_hold_b", input_b, hold_b);
      chk("stall_hold_op", {61'd0, operation}, {61'd0, hold_op});
    end
    out_ready = 1;
    step();
    idle_inputs();
    chk("nobubble_out_valid", {63'd0, out_valid}, 1);
    chk("nobubble_a", input_a, 64'h1234);
    step();

    // Same-edge write and read of x7.
    write_back(1, 5'd7, 64'h10);
    step();
    issue(5'd7, 5'd7, 0, 64'h0, 3'd2);
    write_back(1, 5'd7, 64'h20);
    step();
    idle_inputs();
`ifdef OPERAND_BYPASS_EN
    chk("same_edge_a", input_a, 64'h20);
`else
    chk("same_edge_a", input_a, 64'h10);
`endif
    step();

    // Randomised traffic with back-pressure and concurrent write-back.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(3) != 0)
        issue(5'($urandom), 5'($urandom), 1'($urandom), {$urandom, $urandom}, 3'($urandom));
      else in_valid = 0;
      write_back(1'($urandom), 5'($urandom_range(7)), {$urandom, $urandom});
      out_ready = ($urandom_range(3) != 0);
      step();
    end
    idle_inputs();
    out_ready = 1;
    step(); step();

    // Reset in the middle of a stall drops the entry and clears registers.
    for (int i = 1; i < 32; i++) begin
      write_back(1, 5'(i), 64'h100 + 64'(i));
      step();
    end
    idle_inputs();
    issue(5'd3, 5'd4, 0, 64'h0, 3'd5);
    step();
    idle_inputs();
    out_ready = 0;
    step(); step();
    chk("pre_rst_out_valid", {63'd0, out_valid}, 1);
    rst = 1;
    clear_model();
    #1;
    chk("mid_rst_out_valid", {63'd0, out_valid}, 0);
    chk("mid_rst_in_ready", {63'd0, in_ready}, 1);
    chk("mid_rst_a", input_a, 0);
    chk("mid_rst_b", input_b, 0);
    chk("mid_rst_op", {61'd0, operation}, 0);
    step();
    rst = 0;
    out_ready = 1;
    for (int i = 0; i < 32; i++) begin
      issue(5'(i), 5'(31 - i), 0, 64'h0, 3'd0);
      step();
    end
    idle_inputs();

    budget = 20;
    while (sb.size() != 0 && budget > 0) begin
      step();
      budget--;
    end
    chk("drain_pending", 64'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
